// File: rtl/can_rx_assembler.sv
// CAN receive assembler: collects up to 8 bytes per packet and queues completed packets in a small FIFO.
// Define CAN_RX_ASM_DROP_CNT_EN to enable the drop_pulse / drop_cnt reporting of packets lost to a full FIFO.
//
// state   | meaning
// IDLE    | no packet in progress; next rx byte lands at index 0
// COLLECT | packet in progress; cnt holds the number of bytes captured so far
module can_rx_assembler #(
   parameter int DEPTH_LOG2 = 2,
   parameter int DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic                  rx_last,
   input  logic [7:0]            rx_data,
   input  logic [28:0]           rx_id,
   input  logic                  rx_ide,
   output logic                  pkt_valid,
   input  logic                  pkt_ready,
   output logic [28:0]           pkt_id,
   output logic                  pkt_ide,
   output logic [3:0]            pkt_len,
   output logic [63:0]           pkt_data,
   output logic                  drop_pulse,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int EW    = 29 + 1 + 4 + 64;

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [63:0] stage;
   logic [3:0]  idx;
   logic [3:0]  len_nxt;
   logic [63:0] data_nxt;
   logic        commit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      idx       = 4'd0;
      data_nxt  = 64'h0;
      commit    = rx_valid & rx_last;
      if (state == COLLECT) begin
         idx      = cnt;
         data_nxt = stage;
      end
      // Index 8 and beyond: byte is dropped and the length stays pinned at 8.
      len_nxt = idx[3] ? 4'd8 : idx + 4'd1;
      if (!idx[3]) data_nxt[{~idx[2:0], 3'b000} +: 8] = rx_data;
      case (state)
         IDLE:    if (rx_valid && !rx_last) state_nxt = COLLECT;
         COLLECT: if (commit)               state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= 4'd0;
         stage <= 64'h0;
      end else if (rx_valid) begin
         if (rx_last) begin
            cnt   <= 4'd0;
            stage <= 64'h0;
         end else begin
            cnt   <= len_nxt;
            stage <= data_nxt;
         end
      end
   end

   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
   logic                full, empty, push, pop;
   logic [EW-1:0]       mem [DEPTH];
   logic [EW-1:0]       head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                  (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
   assign push  = commit & ~full;
   assign pop   = pkt_valid & pkt_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {rx_id, rx_ide, len_nxt, data_nxt};
   end

   // Outputs read zero whenever nothing is queued, which also covers reset.
   assign head      = mem[rd_ptr[DEPTH_LOG2-1:0]];
   assign pkt_valid = ~empty;
   assign {pkt_id, pkt_ide, pkt_len, pkt_data} = pkt_valid ? head : '0;

`ifdef CAN_RX_ASM_DROP_CNT_EN
   logic                  drop_q;
   logic [DROP_CNT_W-1:0] drop_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         drop_q <= commit & full;
         if (commit && full && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   assign drop_pulse = drop_q;
   assign drop_cnt   = drop_cnt_q;
`else
   assign drop_pulse = 1'b0;
   assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_can_rx_assembler.sv
// Bench for can_rx_assembler: directed vector table, corner-case sequences and random traffic
// checked against a queue-based packet model.
module tb_can_rx_assembler;

   localparam int DEPTH = 4;
`ifdef CAN_RX_ASM_DROP_CNT_EN
   localparam int DROP_EN = 1;
`else
   localparam int DROP_EN = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0, rx_last = 1'b0, rx_ide = 1'b0, pkt_ready = 1'b0;
   logic [7:0]  rx_data = 8'h0;
   logic [28:0] rx_id = 29'h0;
   logic        pkt_valid, pkt_ide, drop_pulse;
   logic [28:0] pkt_id;
   logic [3:0]  pkt_len;
   logic [63:0] pkt_data;
   logic [7:0]  drop_cnt;

   can_rx_assembler #(.DEPTH_LOG2(2), .DROP_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_last(rx_last), .rx_data(rx_data),
      .rx_id(rx_id), .rx_ide(rx_ide), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_id(pkt_id), .pkt_ide(pkt_ide), .pkt_len(pkt_len), .pkt_data(pkt_data),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [28:0] id;
      logic        ide;
      logic [3:0]  len;
      logic [63:0] data;
   } pkt_t;

   typedef struct {
      logic        v, l, rdy, ide, ev, eide;
      logic [7:0]  d;
      logic [28:0] id, eid;
      logic [3:0]  elen;
      logic [63:0] edata;
   } vec_t;

   pkt_t       mq[$];
   logic [7:0] cur[$];
   logic       exp_dp = 1'b0;
   logic [7:0] exp_dc = 8'h0;
   int         n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      else n_pass++;
   endtask

   // One clock: drive inputs, compare DUT against the model, advance the model, step past the edge.
   task automatic cycle(input logic v, input logic l, input logic [7:0] d,
                        input logic [28:0] id, input logic ide, input logic rdy);
      pkt_t p;
      logic full_m, pop_m;
      rx_valid = v; rx_last = l; rx_data = d; rx_id = id; rx_ide = ide; pkt_ready = rdy;
      chk("pkt_valid", pkt_valid, 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("pkt_id", pkt_id, mq[0].id);
         chk("pkt_ide", pkt_ide, mq[0].ide);
         chk("pkt_len", pkt_len, mq[0].len);
         chk("pkt_data", pkt_data, mq[0].data);
      end
      chk("drop_pulse", drop_pulse, exp_dp);
      chk("drop_cnt", drop_cnt, exp_dc);
      pop_m  = (mq.size() != 0) && rdy;
      full_m = (mq.size() == DEPTH);
      exp_dp = 1'b0;
      p = '{id: id, ide: ide, len: 4'd0, data: 64'h0};
      if (v) cur.push_back(d);
      if (v && l) begin
         p.len = (cur.size() > 8) ? 4'd8 : 4'(cur.size());
         for (int i = 0; i < int'(p.len); i++) p.data[63-8*i -: 8] = cur[i];
         cur.delete();
         if (full_m && DROP_EN == 1) begin
            exp_dp = 1'b1;
            if (exp_dc != 8'hFF) exp_dc = exp_dc + 8'd1;
         end
      end
      if (pop_m) void'(mq.pop_front());
      if (v && l && !full_m) mq.push_back(p);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_valid = 0; rx_last = 0; rx_data = 0; rx_id = 0; rx_ide = 0; pkt_ready = 0;
      mq.delete(); cur.delete(); exp_dp = 1'b0; exp_dc = 8'h0;
      #1;
      chk("rst_valid", pkt_valid, 0);
      chk("rst_len", pkt_len, 0);
      chk("rst_data", pkt_data, 0);
      chk("rst_id", {pkt_id, pkt_ide}, 0);
      chk("rst_drop", {drop_pulse, drop_cnt}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send_pkt(input int n, input logic [7:0] base, input logic [28:0] id,
                           input logic ide, input logic rdy_last);
      for (int i = 0; i < n; i++)
         cycle(1'b1, i == n-1, base + 8'(i), id, ide, (i == n-1) ? rdy_last : 1'b0);
   endtask

   task automatic drain(input string name, input int exp_n);
      int n = 0;
      while (pkt_valid && n < 20) begin
         n++;
         cycle(0, 0, 8'h0, 29'h0, 0, 1'b1);
      end
      chk(name, 64'(n), 64'(exp_n));
   endtask

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{v:1, l:0, rdy:0, ide:0, ev:0, eide:0, d:8'h11, id:29'h123, eid:0, elen:0, edata:0};
      vecs[1] = '{v:1, l:0, rdy:0, ide:0, ev:0, eide:0, d:8'h22, id:29'h123, eid:0, elen:0, edata:0};
      vecs[2] = '{v:1, l:1, rdy:0, ide:0, ev:1, eide:0, d:8'h33, id:29'h123, eid:29'h123,
                  elen:4'd3, edata:64'h1122330000000000};
      vecs[3] = '{v:0, l:0, rdy:1, ide:0, ev:0, eide:0, d:8'h00, id:29'h0, eid:0, elen:0, edata:0};
      vecs[4] = '{v:1, l:1, rdy:0, ide:1, ev:1, eide:1, d:8'hAB, id:29'h12345678, eid:29'h12345678,
                  elen:4'd1, edata:64'hAB00000000000000};
      vecs[5] = '{v:0, l:1, rdy:0, ide:0, ev:1, eide:1, d:8'hCD, id:29'h0, eid:29'h12345678,
                  elen:4'd1, edata:64'hAB00000000000000};
      vecs[6] = '{v:0, l:0, rdy:1, ide:0, ev:0, eide:0, d:8'h00, id:29'h0, eid:0, elen:0, edata:0};

      do_reset();
      for (int i = 0; i < 7; i++) begin
         cycle(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].id, vecs[i].ide, vecs[i].rdy);
         chk($sformatf("tbl%0d_valid", i), pkt_valid, vecs[i].ev);
         if (vecs[i].ev) begin
            chk($sformatf("tbl%0d_len", i), pkt_len, vecs[i].elen);
            chk($sformatf("tbl%0d_data", i), pkt_data, vecs[i].edata);
            chk($sformatf("tbl%0d_id", i), {pkt_id, pkt_ide}, {vecs[i].eid, vecs[i].eide});
         end
      end

      // Over-length packet: bytes past the eighth are discarded.
      send_pkt(10, 8'h40, 29'h7FF, 1'b0, 1'b0);
      cycle(0, 0, 8'h0, 29'h0, 0, 0);
      chk("ovl_len", pkt_len, 8);
      chk("ovl_data", pkt_data, 64'h4041424344454647);
      drain("ovl_drain", 1);

      // Five packets into a four-deep FIFO with no consumer.
      do_reset();
      for (int p = 0; p < 5; p++) send_pkt(8, 8'(p * 16), 29'(p + 1), 1'b1, 1'b0);
      cycle(0, 0, 8'h0, 29'h0, 0, 0);
      chk("full5_drop_cnt", drop_cnt, 64'(DROP_EN));
      chk("full5_head_id", pkt_id, 1);
      drain("full5_drain", 4);

      // Commit while full with a same-cycle pop: packet still dropped.
      do_reset();
      for (int p = 0; p < 4; p++) send_pkt(3, 8'(8'h80 + p * 4), 29'(p + 16), 1'b0, 1'b0);
      send_pkt(3, 8'hF0, 29'h1F, 1'b0, 1'b1);
      cycle(0, 0, 8'h0, 29'h0, 0, 0);
      chk("fullpop_drop_cnt", drop_cnt, 64'(DROP_EN));
      chk("fullpop_head_id", pkt_id, 17);
      drain("fullpop_drain", 3);

      // Occupancy 2 with commit+pop each cycle, wrapping the pointers.
      do_reset();
      send_pkt(2, 8'h10, 29'h100, 1'b0, 1'b0);
      send_pkt(1, 8'h20, 29'h101, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) send_pkt(1, 8'(8'hA0 + k), 29'(29'h200 + k), 1'b1, 1'b1);
      cycle(0, 0, 8'h0, 29'h0, 0, 0);
      chk("wrap_head_id", pkt_id, 29'h208);
      drain("wrap_drain", 2);

      // Reset in the middle of a packet.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1, 0, 8'(8'hC0 + i), 29'h9, 0, 0);
      do_reset();
      send_pkt(2, 8'h55, 29'h3, 1'b0, 1'b0);
      cycle(0, 0, 8'h0, 29'h0, 0, 0);
      chk("rstmid_len", pkt_len, 2);
      chk("rstmid_data", pkt_data, 64'h5556000000000000);
      drain("rstmid_drain", 1);

      // Random traffic against the model.
      do_reset();
      begin
         logic        ide_r = 1'b0;
         logic [28:0] id_r = 29'h5;
         for (int c = 0; c < 500; c++) begin
            logic v, l;
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 5) == 0);
            cycle(v, l, 8'($urandom), id_r, ide_r, 1'($urandom_range(0, 2) == 0));
            if (v && l) begin
               ide_r = 1'($urandom);
               id_r  = ide_r ? 29'($urandom) : 29'($urandom & 32'h7FF);
            end
         end
         drain("rand_drain", mq.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
